// File: rtl/tea_cipher_core.sv
// Iterative TEA block cipher with runtime encrypt/decrypt, parametrised round count
// and rounds-per-clock unroll, valid/ready on both sides.
module tea_cipher_core #(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [31:0]  v0_in,
    input  logic [31:0]  v1_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  v0_out,
    output logic [31:0]  v1_out,
    output logic         busy
);

    localparam int          STEPS   = ROUNDS / UNROLL;
    localparam int          CNT_W   = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
    localparam logic [31:0] SUM_DEC = 32'(64'(DELTA) * 64'(ROUNDS));

    generate
        if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_params
            $error("tea_cipher_core: ROUNDS must be >= 1 and a multiple of UNROLL");
        end
    endgenerate

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in HOLD, and a held result never changes.
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t             state;
    logic [31:0]        v0_r, v1_r, sum_r;
    logic [127:0]       key_r;
    logic               mode_r;
    logic [CNT_W-1:0]   cnt;

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] nv0, nv1, nsum;

    assign k0 = key_r[127:96];
    assign k1 = key_r[95:64];
    assign k2 = key_r[63:32];
    assign k3 = key_r[31:0];

    function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // UNROLL chained TEA cycles per clock; decrypt walks the schedule backwards.
    always_comb begin
        nv0  = v0_r;
        nv1  = v1_r;
        nsum = sum_r;
        for (int i = 0; i < UNROLL; i++) begin
            if (!mode_r) begin
                nsum = nsum + DELTA;
                nv0  = nv0 + mix(nv1, nsum, k0, k1);
                nv1  = nv1 + mix(nv0, nsum, k2, k3);
            end else begin
                nv1  = nv1 - mix(nv0, nsum, k2, k3);
                nv0  = nv0 - mix(nv1, nsum, k0, k1);
                nsum = nsum - DELTA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            v0_out    <= '0;
            v1_out    <= '0;
            v0_r      <= '0;
            v1_r      <= '0;
            sum_r     <= '0;
            key_r     <= '0;
            mode_r    <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        v0_r     <= v0_in;
                        v1_r     <= v1_in;
                        key_r    <= key_in;
                        mode_r   <= mode;
                        sum_r    <= mode ? SUM_DEC : 32'h0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    v0_r  <= nv0;
                    v1_r  <= nv1;
                    sum_r <= nsum;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        v0_out    <= nv0;
                        v1_out    <= nv1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tea_cipher_core.sv
// Directed bench for tea_cipher_core: three instances (defaults, UNROLL=4, ROUNDS=16)
// checked against known answers and a behavioural TEA model.
module tb_tea_cipher_core;

    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic         clk;
    logic         reset;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         mode_i    [3];
    logic [31:0]  v0_in     [3];
    logic [31:0]  v1_in     [3];
    logic [127:0] key_in    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [31:0]  v0_out    [3];
    logic [31:0]  v1_out    [3];
    logic         busy      [3];

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    tea_cipher_core dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode_i[0]), .v0_in(v0_in[0]), .v1_in(v1_in[0]), .key_in(key_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .v0_out(v0_out[0]),
        .v1_out(v1_out[0]), .busy(busy[0])
    );

    tea_cipher_core #(.UNROLL(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode_i[1]), .v0_in(v0_in[1]), .v1_in(v1_in[1]), .key_in(key_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .v0_out(v0_out[1]),
        .v1_out(v1_out[1]), .busy(busy[1])
    );

    tea_cipher_core #(.ROUNDS(16)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mode(mode_i[2]), .v0_in(v0_in[2]), .v1_in(v1_in[2]), .key_in(key_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .v0_out(v0_out[2]),
        .v1_out(v1_out[2]), .busy(busy[2])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rounds_of(input int idx);
        return (idx == 2) ? 16 : 32;
    endfunction

    function automatic int steps_of(input int idx);
        return (idx == 1) ? 8 : rounds_of(idx);
    endfunction

    // reference TEA, written straight from the algorithm description
    function automatic logic [63:0] tea_model(input logic m, input logic [31:0] a_in,
                                              input logic [31:0] b_in, input logic [127:0] k,
                                              input int rounds);
        logic [31:0] a, b, s, k0, k1, k2, k3;
        a = a_in; b = b_in;
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        if (!m) begin
            s = 32'h0;
            for (int r = 0; r < rounds; r++) begin
                s = s + DELTA;
                a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
                b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
            end
        end else begin
            s = DELTA * 32'(rounds);
            for (int r = 0; r < rounds; r++) begin
                b = b - (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
                a = a - (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
                s = s - DELTA;
            end
        end
        return {a, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int idx, input logic vld, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input logic [127:0] k);
        in_valid[idx] = vld;
        mode_i[idx]   = m;
        v0_in[idx]    = a;
        v1_in[idx]    = b;
        key_in[idx]   = k;
    endtask

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        while (!out_valid[idx] && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic drain(input int idx);
        out_ready[idx] = 1'b1;
        step();
        out_ready[idx] = 1'b0;
    endtask

    task automatic run_block(input int idx, input logic m, input logic [31:0] a,
                             input logic [31:0] b, input logic [127:0] k,
                             output logic [63:0] res, output int lat);
        int guard;
        set_in(idx, 1'b1, m, a, b, k);
        guard = 0;
        while (!in_ready[idx] && guard < 200) begin
            step();
            guard++;
        end
        step();
        in_valid[idx] = 1'b0;
        wait_out(idx, lat);
        res = {v0_out[idx], v1_out[idx]};
        drain(idx);
    endtask

    localparam logic [127:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] KEY_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    initial begin
        logic [63:0] res, enc, hv;
        int lat, cyc, acc, got, last_acc;
        logic [63:0] blk_v[4];

        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
            out_ready[i] = 1'b0;
        end
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        // reset state
        check("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_v0_out", 64'(v0_out[0]), 64'd0);
        check("rst_v1_out", 64'(v1_out[0]), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // known answer, defaults
        run_block(0, 1'b0, 32'h0, 32'h0, 128'h0, res, lat);
        check("kat_latency", 64'(lat), 64'd32);
        check("kat_result", res, 64'h41EA3A0A_94BAA940);

        // round trips on all three configurations
        for (int i = 0; i < 3; i++) begin
            run_block(i, 1'b0, 32'h01234567, 32'h89ABCDEF, KEY_A, enc, lat);
            check($sformatf("rt%0d_enc_latency", i), 64'(lat), 64'(steps_of(i)));
            check($sformatf("rt%0d_enc_result", i), enc,
                  tea_model(1'b0, 32'h01234567, 32'h89ABCDEF, KEY_A, rounds_of(i)));
            run_block(i, 1'b1, enc[63:32], enc[31:0], KEY_A, res, lat);
            check($sformatf("rt%0d_dec_latency", i), 64'(lat), 64'(steps_of(i)));
            check($sformatf("rt%0d_dec_result", i), res, 64'h01234567_89ABCDEF);
        end

        // backpressure: result held, new block ignored until the output handshake
        set_in(0, 1'b1, 1'b0, 32'h01234567, 32'h89ABCDEF, KEY_A);
        step();
        in_valid[0] = 1'b0;
        wait_out(0, lat);
        hv = {v0_out[0], v1_out[0]};
        check("bp_first_result", hv, tea_model(1'b0, 32'h01234567, 32'h89ABCDEF, KEY_A, 32));
        set_in(0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0BADF00D, KEY_B);
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_hold_data", {v0_out[0], v1_out[0]}, hv);
            check("bp_hold_in_ready", 64'(in_ready[0]), 64'd0);
            check("bp_hold_out_valid", 64'(out_valid[0]), 64'd1);
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        check("bp_release_out_valid", 64'(out_valid[0]), 64'd0);
        check("bp_release_in_ready", 64'(in_ready[0]), 64'd1);
        check("bp_release_busy", 64'(busy[0]), 64'd0);
        step();
        in_valid[0] = 1'b0;
        check("bp_accept_busy", 64'(busy[0]), 64'd1);
        check("bp_accept_in_ready", 64'(in_ready[0]), 64'd0);
        wait_out(0, lat);
        check("bp_second_latency", 64'(lat), 64'd32);
        check("bp_second_result", {v0_out[0], v1_out[0]},
              tea_model(1'b0, 32'hDEADBEEF, 32'h0BADF00D, KEY_B, 32));
        drain(0);

        // input isolation: scramble inputs every clock while the block runs
        set_in(0, 1'b1, 1'b0, 32'h0, 32'h0, 128'h0);
        step();
        lat = 0;
        while (!out_valid[0] && lat < 200) begin
            mode_i[0] = 1'($urandom_range(0, 1));
            v0_in[0]  = $urandom;
            key_in[0] = {$urandom, $urandom, $urandom, $urandom};
            step();
            lat++;
        end
        in_valid[0] = 1'b0;
        check("iso_latency", 64'(lat), 64'd32);
        check("iso_result", {v0_out[0], v1_out[0]}, 64'h41EA3A0A_94BAA940);
        drain(0);

        // asynchronous reset mid-RUN
        set_in(0, 1'b1, 1'b0, 32'h01234567, 32'h89ABCDEF, KEY_A);
        step();
        in_valid[0] = 1'b0;
        repeat (10) step();
        check("mid_busy_before_reset", 64'(busy[0]), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("mid_rst_busy", 64'(busy[0]), 64'd0);
        check("mid_rst_v0_out", 64'(v0_out[0]), 64'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
        run_block(0, 1'b0, 32'h0, 32'h0, 128'h0, res, lat);
        check("post_rst_latency", 64'(lat), 64'd32);
        check("post_rst_result", res, 64'h41EA3A0A_94BAA940);

        // back-to-back throughput on the UNROLL=4 instance
        blk_v[0] = 64'h00000000_00000001;
        blk_v[1] = 64'hCAFEBABE_12345678;
        blk_v[2] = 64'hFFFFFFFF_FFFFFFFF;
        blk_v[3] = 64'h0BADC0DE_FEEDFACE;
        set_in(1, 1'b1, 1'b0, blk_v[0][63:32], blk_v[0][31:0], KEY_B);
        out_ready[1] = 1'b1;
        cyc = 0; acc = 0; got = 0; last_acc = 0;
        while (got < 4 && cyc < 400) begin
            if (out_valid[1]) begin
                if (exp_q.size() > 0) begin
                    check("b2b_result", {v0_out[1], v1_out[1]}, exp_q.pop_front());
                end else begin
                    check("b2b_unexpected_out", 64'd1, 64'd0);
                end
                got++;
            end
            if (in_valid[1] && in_ready[1]) begin
                exp_q.push_back(tea_model(1'b0, blk_v[acc][63:32], blk_v[acc][31:0], KEY_B, 32));
                if (acc > 0) check("b2b_period", 64'(cyc - last_acc), 64'd10);
                last_acc = cyc;
                acc++;
                step();
                if (acc < 4) set_in(1, 1'b1, 1'b0, blk_v[acc][63:32], blk_v[acc][31:0], KEY_B);
                else in_valid[1] = 1'b0;
            end else begin
                step();
            end
            cyc++;
        end
        out_ready[1] = 1'b0;
        check("b2b_blocks_out", 64'(got), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
